// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op from execute, drives a single-beat data-memory
// request with lane-replicated write data, and returns an extended load or an error pulse.
module load_store_unit #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_is_load;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic        r_ld_valid;
    logic [31:0] r_ld_data;
    logic        r_err_valid;
    logic [1:0]  r_err_code;
    logic        r_dmem_req;
    logic        r_dmem_we;
    logic [31:0] r_dmem_addr;
    logic [31:0] r_dmem_wdata;
    logic [3:0]  r_dmem_be;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misaligned;
    logic [1:0]  w_err_code;
    logic [31:0] w_store_wdata;
    logic [3:0]  w_store_be;
    logic [31:0] w_load_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_accept = (r_state == S_IDLE) && ex_valid && (mem_read || mem_write);

    always_comb begin
        w_illegal = 1'b0;
        if (mem_read && mem_write) begin
            w_illegal = 1'b1;
        end else if (mem_read) begin
            w_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end else if (mem_write) begin
            w_illegal = (funct3 != 3'b000) && (funct3 != 3'b001) && (funct3 != 3'b010);
        end
    end

    // Legality is checked first, so funct3[1:0] alone identifies the access size here.
    always_comb begin
        w_misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   w_misaligned = alu_result[0];
            2'b10:   w_misaligned = (alu_result[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_err_code = w_illegal ? ERR_ILLEGAL : (w_misaligned ? ERR_MISALIGN : 2'b00);

    always_comb begin
        w_store_wdata = store_data;
        w_store_be    = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                w_store_wdata = {4{store_data[7:0]}};
                w_store_be    = 4'b0001 << alu_result[1:0];
            end
            2'b01: begin
                w_store_wdata = {2{store_data[15:0]}};
                w_store_be    = alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_store_wdata = store_data;
                w_store_be    = 4'b1111;
            end
        endcase
    end

    always_comb begin
        case (r_addr_lo)
            2'b00:   w_byte = dmem_rdata[7:0];
            2'b01:   w_byte = dmem_rdata[15:8];
            2'b10:   w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    end

    // funct3[2] marks the unsigned load variants.
    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_load_data = r_funct3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_data = r_funct3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_is_load    <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr_lo    <= 2'd0;
            r_ld_valid   <= 1'b0;
            r_ld_data    <= 32'd0;
            r_err_valid  <= 1'b0;
            r_err_code   <= 2'd0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= 32'd0;
            r_dmem_wdata <= 32'd0;
            r_dmem_be    <= 4'd0;
        end else begin
            r_ld_valid  <= 1'b0;
            r_err_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_funct3  <= funct3;
                        r_addr_lo <= alu_result[1:0];
                        r_is_load <= mem_read && !mem_write;
                        if (w_err_code != 2'b00) begin
                            r_state     <= S_DONE;
                            r_err_valid <= 1'b1;
                            r_err_code  <= w_err_code;
                        end else begin
                            r_state      <= S_REQ;
                            r_cnt        <= 8'd0;
                            r_dmem_req   <= 1'b1;
                            r_dmem_we    <= mem_write;
                            r_dmem_addr  <= {alu_result[31:2], 2'b00};
                            r_dmem_wdata <= mem_write ? w_store_wdata : 32'd0;
                            r_dmem_be    <= mem_write ? w_store_be : 4'b1111;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_ack) begin
                        r_state    <= S_DONE;
                        r_dmem_req <= 1'b0;
                        if (r_is_load) begin
                            r_ld_valid <= 1'b1;
                            r_ld_data  <= w_load_data;
                        end
                    end else if ((r_cnt + 8'd1) == TIMEOUT_LIMIT) begin
                        r_state     <= S_DONE;
                        r_dmem_req  <= 1'b0;
                        r_err_valid <= 1'b1;
                        r_err_code  <= ERR_TIMEOUT;
                        r_ld_data   <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Gated by rst_n so the pipeline never sees a stall while held in reset.
    assign stall      = rst_n && (w_accept || (r_state == S_REQ));
    assign ld_valid   = r_ld_valid;
    assign ld_data    = r_ld_data;
    assign err_valid  = r_err_valid;
    assign err_code   = r_err_code;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign dmem_be    = r_dmem_be;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a short memory timeout.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        err_valid;
    logic [1:0]  err_code;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .alu_result (alu_result),
        .store_data (store_data),
        .stall      (stall),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sdata);
        ex_valid   = 1'b1;
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        alu_result = addr;
        store_data = sdata;
    endtask

    task automatic drop_op();
        ex_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp, input int waits);
        drive_op(1'b1, 1'b0, f3, addr, 32'h0);
        #1 chk({tag, " stall_accept"}, 32'(stall), 32'd1);
        next_cycle();
        chk({tag, " req"}, 32'(dmem_req), 32'd1);
        chk({tag, " addr"}, dmem_addr, {addr[31:2], 2'b00});
        chk({tag, " be"}, 32'(dmem_be), 32'hF);
        chk({tag, " we"}, 32'(dmem_we), 32'd0);
        for (int i = 0; i < waits; i++) begin
            chk({tag, " stall_wait"}, 32'(stall), 32'd1);
            next_cycle();
            chk({tag, " req_wait"}, 32'(dmem_req), 32'd1);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        #1 chk({tag, " stall_req"}, 32'(stall), 32'd1);
        next_cycle();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        chk({tag, " ld_valid"}, 32'(ld_valid), 32'd1);
        chk({tag, " ld_data"}, ld_data, exp);
        chk({tag, " err_valid"}, 32'(err_valid), 32'd0);
        chk({tag, " stall_done"}, 32'(stall), 32'd0);
        chk({tag, " req_done"}, 32'(dmem_req), 32'd0);
        next_cycle();
        chk({tag, " no_reaccept"}, 32'(dmem_req), 32'd0);
        chk({tag, " ld_pulse"}, 32'(ld_valid), 32'd0);
        drop_op();
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        drive_op(1'b0, 1'b1, f3, addr, sdata);
        #1 chk({tag, " stall_accept"}, 32'(stall), 32'd1);
        next_cycle();
        chk({tag, " req"}, 32'(dmem_req), 32'd1);
        chk({tag, " we"}, 32'(dmem_we), 32'd1);
        chk({tag, " addr"}, dmem_addr, exp_addr);
        chk({tag, " be"}, 32'(dmem_be), 32'(exp_be));
        chk({tag, " wdata"}, dmem_wdata, exp_wdata);
        dmem_ack = 1'b1;
        next_cycle();
        dmem_ack = 1'b0;
        chk({tag, " ld_valid"}, 32'(ld_valid), 32'd0);
        chk({tag, " err_valid"}, 32'(err_valid), 32'd0);
        chk({tag, " stall_done"}, 32'(stall), 32'd0);
        chk({tag, " req_done"}, 32'(dmem_req), 32'd0);
        next_cycle();
        drop_op();
    endtask

    task automatic do_err(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [1:0] exp_code);
        drive_op(rd, wr, f3, addr, 32'hCAFE_F00D);
        #1 chk({tag, " stall_accept"}, 32'(stall), 32'd1);
        next_cycle();
        chk({tag, " req"}, 32'(dmem_req), 32'd0);
        chk({tag, " err_valid"}, 32'(err_valid), 32'd1);
        chk({tag, " err_code"}, 32'(err_code), 32'(exp_code));
        chk({tag, " ld_valid"}, 32'(ld_valid), 32'd0);
        chk({tag, " stall_done"}, 32'(stall), 32'd0);
        next_cycle();
        drop_op();
        chk({tag, " err_pulse"}, 32'(err_valid), 32'd0);
        chk({tag, " req_after"}, 32'(dmem_req), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        alu_result = 32'h0;
        store_data = 32'h0;
        funct3     = 3'b000;
        drop_op();
        #12;
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst ld_valid", 32'(ld_valid), 32'd0);
        chk("rst ld_data", ld_data, 32'd0);
        chk("rst err_valid", 32'(err_valid), 32'd0);
        chk("rst err_code", 32'(err_code), 32'd0);
        chk("rst req", 32'(dmem_req), 32'd0);
        chk("rst we", 32'(dmem_we), 32'd0);
        chk("rst addr", dmem_addr, 32'd0);
        chk("rst wdata", dmem_wdata, 32'd0);
        chk("rst be", 32'(dmem_be), 32'd0);
        rst_n = 1'b1;

        do_load("lw0", 3'b010, 32'h0000_0100, 32'h8000_00FF, 32'h8000_00FF, 0);
        do_load("lb", 3'b000, 32'h0000_0103, 32'h80FF_FFFF, 32'hFFFF_FF80, 0);
        do_load("lbu", 3'b100, 32'h0000_0103, 32'h80FF_FFFF, 32'h0000_0080, 1);
        do_load("lhu", 3'b101, 32'h0000_0102, 32'h80FF_FFFF, 32'h0000_80FF, 0);
        do_load("lh_hi", 3'b001, 32'h0000_0102, 32'h80FF_FFFF, 32'hFFFF_80FF, 2);
        do_load("lh_lo", 3'b001, 32'h0000_0100, 32'h1234_F00D, 32'hFFFF_F00D, 0);
        do_load("lb1", 3'b000, 32'h0000_0101, 32'h1234_5678, 32'h0000_0056, 0);

        do_store("sh_hi", 3'b001, 32'h0000_0206, 32'h1234_ABCD, 32'h0000_0204, 4'b1100, 32'hABCD_ABCD);
        chk("ld_data hold", ld_data, 32'h0000_0056);
        do_store("sh_lo", 3'b001, 32'h0000_0200, 32'h1234_ABCD, 32'h0000_0200, 4'b0011, 32'hABCD_ABCD);
        do_store("sb", 3'b000, 32'h0000_0301, 32'hAABB_CC5A, 32'h0000_0300, 4'b0010, 32'h5A5A_5A5A);
        do_store("sw", 3'b010, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0000_0400, 4'b1111, 32'hDEAD_BEEF);

        do_err("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0101, 2'b01);
        do_err("rw_both", 1'b1, 1'b1, 3'b010, 32'h0000_0100, 2'b11);
        do_err("ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h0000_0100, 2'b11);
        do_err("st_f3_100", 1'b0, 1'b1, 3'b100, 32'h0000_0100, 2'b11);
        do_err("sh_mis", 1'b0, 1'b1, 3'b001, 32'h0000_0203, 2'b01);
        do_err("ill_prio", 1'b1, 1'b0, 3'b111, 32'h0000_0101, 2'b11);
        do_err("lhu_mis", 1'b1, 1'b0, 3'b101, 32'h0000_0105, 2'b01);
        do_load("lw_after_err", 3'b010, 32'h0000_0104, 32'h0BAD_F00D, 32'h0BAD_F00D, 0);

        drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            chk("tmo req", 32'(dmem_req), 32'd1);
            chk("tmo stall", 32'(stall), 32'd1);
            next_cycle();
        end
        chk("tmo req_drop", 32'(dmem_req), 32'd0);
        chk("tmo err_valid", 32'(err_valid), 32'd1);
        chk("tmo err_code", 32'(err_code), 32'd2);
        chk("tmo ld_valid", 32'(ld_valid), 32'd0);
        chk("tmo ld_data", ld_data, 32'd0);
        chk("tmo stall_done", 32'(stall), 32'd0);
        next_cycle();
        drop_op();
        chk("tmo err_pulse", 32'(err_valid), 32'd0);

        do_load("lw_pre_rst", 3'b010, 32'h0000_0108, 32'h7777_1111, 32'h7777_1111, 0);
        drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0);
        next_cycle();
        chk("mid req", 32'(dmem_req), 32'd1);
        #1 rst_n = 1'b0;
        drop_op();
        #1;
        chk("mrst req", 32'(dmem_req), 32'd0);
        chk("mrst stall", 32'(stall), 32'd0);
        chk("mrst ld_data", ld_data, 32'd0);
        chk("mrst addr", dmem_addr, 32'd0);
        chk("mrst be", 32'(dmem_be), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h5555_5555;
        next_cycle();
        dmem_ack = 1'b0;
        chk("post_rst ld_valid", 32'(ld_valid), 32'd0);
        chk("post_rst err_valid", 32'(err_valid), 32'd0);
        chk("post_rst req", 32'(dmem_req), 32'd0);
        next_cycle();
        chk("post_rst ld_valid2", 32'(ld_valid), 32'd0);
        do_load("lw_post_rst", 3'b010, 32'h0000_0600, 32'h1357_9BDF, 32'h1357_9BDF, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum cycles dmem_req is held without dmem_ack before abort (1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ex_valid  input  1  execute stage presents a memory operation.
REQ-005 mem_read  input  1  operation is a load.
REQ-006 mem_write  input  1  operation is a store.
REQ-007 funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-008 alu_result  input  32  effective byte address from ALU ADD path.
REQ-009 store_data  input  32  rs2 value for stores.
REQ-010 stall  output  1  freeze PC and pipeline while high.
REQ-011 ld_valid  output  1  one-cycle pulse: ld_data valid.
REQ-012 ld_data  output  32  extended load result.
REQ-013 err_valid  output  1  one-cycle pulse with err_code.
REQ-014 err_code  output  2  01 misaligned, 10 timeout, 11 illegal op.
REQ-015 dmem_req/dmem_we  output  1/1  memory request, write enable.
REQ-016 dmem_addr  output  32  word-aligned address {alu_result[31:2],2'b00}.
REQ-017 dmem_wdata/dmem_be  output  32/4  lane-replicated store data, byte enables.
REQ-018 dmem_ack/dmem_rdata  input  1/32  request accepted; read word valid same cycle as ack.

Function
REQ-019 FSM states IDLE, REQ, DONE; IDLE->REQ on legal accepted op, IDLE->DONE on error op, REQ->DONE on ack or timeout, DONE->IDLE unconditionally.
REQ-020 Accept in IDLE when ex_valid & (mem_read|mem_write); address, data, funct3, direction registered at that edge.
REQ-021 stall combinational: high in IDLE when an op is accepted, high in REQ, low in DONE and idle IDLE.
REQ-022 Illegal (err 11): mem_read & mem_write both high, load funct3 in {011,110,111}, store funct3 not in {000,001,010}; no dmem_req issued.
REQ-023 Misaligned (err 01): H/HU/SH with addr[0]=1, W/SW with addr[1:0]!=0; no dmem_req issued; illegal takes priority over misaligned.
REQ-024 dmem_req registered: high every REQ cycle, dmem_addr/we/wdata/be stable until ack sampled; dropped the cycle after ack.
REQ-025 Loads: dmem_be=1111; B lane addr[1:0] sign-extend bit 7; BU zero-extend; H lane addr[1] sign-extend bit 15; HU zero-extend; W unchanged.
REQ-026 Stores: SB wdata {4{b}}, be 0001<<addr[1:0]; SH {2{h}}, be 0011<<(2*addr[1]); SW full word, be 1111.
REQ-027 Zero-wait latency: accept cycle N, req N+1 with ack N+1, DONE N+2 (ld_valid for loads, stall low); +1 cycle per ack wait.
REQ-028 Timeout counter cleared on entering REQ, increments each REQ cycle without ack; at MEM_TIMEOUT cycles req drops, DONE with err 10, ld_valid low, ld_data 0.
REQ-029 ld_data holds last value until next ld_valid; err_valid and ld_valid never both high.
REQ-030 DONE ignores ex_valid (same instruction still presented); new op accepted only from IDLE the following cycle.
REQ-031 Error op: stall high in accept cycle only, err_valid pulse in DONE (N+1).

Reset
REQ-032 rst_n low asynchronously forces IDLE, counter 0, every output 0 (stall, ld_valid, ld_data, err_valid, err_code, dmem_*).
REQ-033 Reset mid-REQ abandons transaction; dmem_req drops immediately; no ld_valid or err_valid after release.
REQ-034 First op accepted on first rising edge with rst_n high.

Verification
REQ-035 LW addr 0x100, ack same cycle, rdata 0x8000_00FF -> ld_valid at N+2, ld_data 0x8000_00FF, stall high N..N+1.
REQ-036 LB addr 0x103, rdata 0x80FF_FFFF -> ld_data 0xFFFF_FF80; LBU same -> 0x0000_0080; LHU addr 0x102 -> 0x0000_80FF.
REQ-037 SH addr 0x206, store_data 0x1234_ABCD -> dmem_addr 0x204, be 1100, wdata 0xABCD_ABCD, we 1, ld_valid never.
REQ-038 LW addr 0x101 -> no dmem_req, err_valid at N+1 code 01; mem_read&mem_write -> code 11.
REQ-039 MEM_TIMEOUT=4, ack never -> req high 4 cycles, then err code 10, stall low in DONE.
REQ-040 rst_n low during REQ with ack pending -> all outputs 0 immediately, IDLE, next LW completes normally.
